// File: rtl/video_sync_decoder.sv
// -----------------------------------------------------------------------------
// video_sync_decoder
//
// Receive side of the VGA sync interface. Measures active-high hsync/vsync
// (as produced by the sync generator before pin inversion) and reports line
// length, hsync pulse width and lines per frame. It raises a lock flag once
// the timing has been stable for LOCK_FRAMES consecutive frames. All inputs
// are synchronous to i_clk; there is no synchronizer inside.
//
// Ports
//   i_clk          pixel clock
//   i_rst_n        asynchronous reset, active-low
//   i_hsync        horizontal sync, active-high
//   i_vsync        vertical sync, active-high
//   o_hpos         clocks since the last hsync rising edge
//   o_line_len     clocks between the last two hsync rising edges
//   o_hsync_width  clocks hsync was high in its last completed pulse
//   o_frame_lines  hsync rising edges between the last two vsync rising edges
//   o_frame_stb    one-cycle pulse: o_frame_lines was just updated
//   o_locked       timing stable for LOCK_FRAMES frames
//
// All counters and measurements saturate at all-ones. A saturated h_cnt or
// v_cnt means the syncs have stopped, and this drops the decoder back to SEARCH.
// -----------------------------------------------------------------------------
module video_sync_decoder #(
  parameter int H_W         = 12,
  parameter int V_W         = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_hsync,
  input  logic           i_vsync,
  output logic [H_W-1:0] o_hpos,
  output logic [H_W-1:0] o_line_len,
  output logic [H_W-1:0] o_hsync_width,
  output logic [V_W-1:0] o_frame_lines,
  output logic           o_frame_stb,
  output logic           o_locked
);

  localparam logic [H_W-1:0] H_MAX = '1;
  localparam logic [V_W-1:0] V_MAX = '1;
  localparam int             LC_W  = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } state_t;

  logic           hs_prev;
  logic           vs_prev;
  logic [H_W-1:0] h_cnt;
  logic [H_W-1:0] w_cnt;
  logic [V_W-1:0] v_cnt;
  logic           mismatch;
  logic [LC_W-1:0] lock_cnt;
  logic [LC_W-1:0] lock_cnt_nxt;
  state_t         state;
  state_t         state_nxt;

  logic           hs_rise;
  logic           hs_fall;
  logic           vs_rise;
  logic [H_W-1:0] h_inc;
  logic [H_W-1:0] w_inc;
  logic [V_W-1:0] v_inc;
  logic [LC_W-1:0] lock_inc;
  logic           timeout;
  logic           good;

  assign hs_rise  = i_hsync & ~hs_prev;
  assign hs_fall  = ~i_hsync & hs_prev;
  assign vs_rise  = i_vsync & ~vs_prev;

  assign h_inc    = (h_cnt == H_MAX) ? h_cnt : h_cnt + 1'b1;
  assign w_inc    = (w_cnt == H_MAX) ? w_cnt : w_cnt + 1'b1;
  assign v_inc    = (v_cnt == V_MAX) ? v_cnt : v_cnt + 1'b1;
  assign lock_inc = lock_cnt + 1'b1;

  assign timeout  = (h_cnt == H_MAX) | (v_cnt == V_MAX);
  // The frame being closed by this vs_rise is judged against the previous one.
  assign good     = (v_cnt == o_frame_lines) & ~mismatch;

  assign o_hpos   = h_cnt;

  // ---------------------------------------------------------------------------
  // Edge detection and measurement counters
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every register here
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // Previous-sample registers reset high: a sync already high when reset
      // releases is mid-pulse, not a fresh rising edge.
      hs_prev       <= 1'b1;
      vs_prev       <= 1'b1;
      h_cnt         <= '0;
      w_cnt         <= '0;
      v_cnt         <= '0;
      mismatch      <= 1'b0;
      o_line_len    <= '0;
      o_hsync_width <= '0;
      o_frame_lines <= '0;
      o_frame_stb   <= 1'b0;
    end else begin
      hs_prev     <= i_hsync;
      vs_prev     <= i_vsync;
      o_frame_stb <= vs_rise;

      if (hs_rise) begin
        h_cnt      <= '0;
        o_line_len <= h_inc;
      end else begin
        h_cnt <= h_inc;
      end

      if (hs_rise) begin
        w_cnt <= H_W'(1);
      end else if (i_hsync) begin
        w_cnt <= w_inc;
      end

      if (hs_fall) begin
        o_hsync_width <= w_cnt;
      end

      if (vs_rise) begin
        // A new frame starts clean; any line compare in this cycle is dropped.
        o_frame_lines <= v_cnt;
        v_cnt         <= hs_rise ? V_W'(1) : '0;
        mismatch      <= 1'b0;
      end else begin
        if (hs_rise) begin
          v_cnt <= v_inc;
        end
        if (hs_rise && (h_inc != o_line_len)) begin
          mismatch <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= SEARCH;
      lock_cnt <= '0;
      o_locked <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      o_locked <= (state_nxt == LOCKED);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;

    if (timeout) begin
      state_nxt    = SEARCH;
      lock_cnt_nxt = '0;
    end else if (vs_rise) begin
      unique case (state)
        SEARCH: begin
          // The first captured frame is partial and is never judged.
          state_nxt    = TRACK;
          lock_cnt_nxt = '0;
        end
        TRACK: begin
          if (good) begin
            lock_cnt_nxt = lock_inc;
            if (lock_inc == LC_W'(LOCK_FRAMES)) begin
              state_nxt = LOCKED;
            end
          end else begin
            lock_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            state_nxt    = TRACK;
            lock_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = SEARCH;
          lock_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_video_sync_decoder
//
// Drives sync streams of randomized shape plus random sync noise. Each cycle
// it compares every output with a reference model. The model works from
// event timestamps: the time of the last hsync rise, the length of the current
// high run, and the number of rises since the last vsync rise. Lock is tracked
// as an "armed" flag plus a count of consecutive good frames. Named checks pin
// the headline values of each scenario to constants.
// -----------------------------------------------------------------------------
module tb_video_sync_decoder;

  localparam int H_W         = 12;
  localparam int V_W         = 11;
  localparam int LOCK_FRAMES = 2;
  localparam int H_MAX       = (1 << H_W) - 1;
  localparam int V_MAX       = (1 << V_W) - 1;

  logic           i_clk   = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_hsync = 1'b0;
  logic           i_vsync = 1'b0;
  logic [H_W-1:0] o_hpos;
  logic [H_W-1:0] o_line_len;
  logic [H_W-1:0] o_hsync_width;
  logic [V_W-1:0] o_frame_lines;
  logic           o_frame_stb;
  logic           o_locked;

  int n_total = 0;
  int n_bad   = 0;

  // Stream shape used by run_lines.
  int llen, hw, nl, vs_hpos;

  // Reference model state.
  int k, t_hr, hi_len, m_hpos, m_len, m_wid, m_lines, vcnt, streak;
  bit hs_p, vs_p, m_stb, m_lock, bad, armed;

  video_sync_decoder #(
    .H_W        (H_W),
    .V_W        (V_W),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_hsync      (i_hsync),
    .i_vsync      (i_vsync),
    .o_hpos       (o_hpos),
    .o_line_len   (o_line_len),
    .o_hsync_width(o_hsync_width),
    .o_frame_lines(o_frame_lines),
    .o_frame_stb  (o_frame_stb),
    .o_locked     (o_locked)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int sat(input int x, input int mx);
    return (x > mx) ? mx : x;
  endfunction

  function automatic logic [63:0] dut_vec();
    return {15'd0, o_hpos, o_line_len, o_hsync_width, o_frame_lines, o_frame_stb, o_locked};
  endfunction

  function automatic logic [63:0] model_vec();
    return {15'd0, H_W'(m_hpos), H_W'(m_len), H_W'(m_wid), V_W'(m_lines), m_stb, m_lock};
  endfunction

  task automatic model_reset();
    k = 0; t_hr = 0; hi_len = 0;
    m_hpos = 0; m_len = 0; m_wid = 0; m_lines = 0; vcnt = 0; streak = 0;
    hs_p = 1'b1; vs_p = 1'b1;
    m_stb = 1'b0; m_lock = 1'b0; bad = 1'b0; armed = 1'b0;
  endtask

  task automatic model_step();
    bit hr, hf, vr, tmo;
    int new_len;
    k++;
    hr  = i_hsync && !hs_p;
    hf  = !i_hsync && hs_p;
    vr  = i_vsync && !vs_p;
    tmo = (m_hpos == H_MAX) || (vcnt == V_MAX);
    new_len = sat(k - t_hr, H_MAX);

    // A line of different length inside a frame spoils that frame.
    if (hr && !vr && new_len != m_len) bad = 1'b1;
    if (hf) m_wid = hi_len;
    hi_len = i_hsync ? sat(hi_len + 1, H_MAX) : 0;

    if (tmo) begin
      armed = 1'b0; streak = 0;
    end else if (vr) begin
      if (!armed) begin
        armed = 1'b1; streak = 0;
      end else if (vcnt == m_lines && !bad) begin
        streak++;
      end else begin
        streak = 0;
      end
    end
    m_lock = armed && (streak >= LOCK_FRAMES);

    m_stb = vr;
    if (vr) begin
      m_lines = vcnt;
      vcnt    = hr ? 1 : 0;
      bad     = 1'b0;
    end else if (hr) begin
      vcnt = sat(vcnt + 1, V_MAX);
    end

    if (hr) begin
      m_len = new_len;
      t_hr  = k;
    end
    m_hpos = sat(k - t_hr, H_MAX);
    hs_p = i_hsync;
    vs_p = i_vsync;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) model_reset();
      else          model_step();
    end
  end

  initial begin
    forever begin
      @(negedge i_clk);
      check("cyc", dut_vec(), model_vec());
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0; i_hsync = 1'b0; i_vsync = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // Drives count lines starting at frame line start_line; the line with call
  // index stretch_at gets one extra clock.
  task automatic run_lines(input int count, input int start_line, input int stretch_at);
    for (int i = 0; i < count; i++) begin
      int l   = (start_line + i) % nl;
      int len = llen + ((i == stretch_at) ? 1 : 0);
      for (int p = 0; p < len; p++) begin
        @(negedge i_clk);
        i_hsync = (p < hw);
        i_vsync = (l == 0 && p >= vs_hpos) || (l == 1) || (l == 2 && p < vs_hpos);
      end
    end
  endtask

  initial begin
    // T1: reset held while syncs toggle.
    repeat (20) begin
      @(negedge i_clk);
      i_hsync = 1'($urandom_range(0, 1));
      i_vsync = 1'($urandom_range(0, 1));
      check("t1_outs", dut_vec(), 64'd0);
    end
    i_hsync = 1'b0; i_vsync = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // T2: full-size line, then a 525-line frame on short lines.
    llen = 800; hw = 96; nl = 525; vs_hpos = 0;
    run_lines(6, 0, -1);
    check("t2_len", 64'(o_line_len), 64'd800);
    check("t2_width", 64'(o_hsync_width), 64'd96);

    do_reset();
    llen = 16; hw = 2;
    run_lines(2 * 525 + 1, 0, -1);
    check("t2_lines", 64'(o_frame_lines), 64'd525);
    check("t2_len16", 64'(o_line_len), 64'd16);

    // T2: lock on a randomized stream shape.
    do_reset();
    llen = $urandom_range(48, 80); hw = $urandom_range(4, 12); nl = $urandom_range(20, 30);
    run_lines(3 * nl, 0, -1);
    check("t2_prelock", 64'(o_locked), 64'd0);
    run_lines(nl, 0, -1);
    check("t2_lock", 64'(o_locked), 64'd1);
    check("t2_flines", 64'(o_frame_lines), 64'(nl));
    check("t2_llen", 64'(o_line_len), 64'(llen));
    check("t2_hw", 64'(o_hsync_width), 64'(hw));

    // T3: one stretched line breaks lock; two good frames restore it.
    run_lines(nl, 0, $urandom_range(3, nl - 3));
    run_lines(nl, 0, -1);
    check("t3_drop", 64'(o_locked), 64'd0);
    run_lines(2 * nl, 0, -1);
    check("t3_relock", 64'(o_locked), 64'd1);

    // T4: hsync stops -> timeout; restart mid-frame and relock.
    repeat (H_MAX + 100) begin
      @(negedge i_clk);
      i_hsync = 1'b0; i_vsync = 1'b0;
    end
    check("t4_hpos", 64'(o_hpos), 64'(H_MAX));
    check("t4_unlock", 64'(o_locked), 64'd0);
    begin
      int sl = $urandom_range(5, nl - 1);
      run_lines(nl - sl, sl, -1);
    end
    run_lines(3 * nl, 0, -1);
    check("t4_prelock", 64'(o_locked), 64'd0);
    run_lines(nl, 0, -1);
    check("t4_relock", 64'(o_locked), 64'd1);

    // T5: vsync rising mid-line.
    do_reset();
    vs_hpos = $urandom_range(hw + 4, llen - 4);
    run_lines(4 * nl, 0, -1);
    check("t5_flines", 64'(o_frame_lines), 64'(nl));
    check("t5_lock", 64'(o_locked), 64'd1);

    // T6: asynchronous reset mid-frame while locked.
    run_lines(nl / 2, 0, -1);
    #3 i_rst_n = 1'b0;
    #1 check("t6_async", dut_vec(), 64'd0);
    i_hsync = 1'b0; i_vsync = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    vs_hpos = 0;
    run_lines(4 * nl, 0, -1);
    check("t6_relock", 64'(o_locked), 64'd1);

    // Random sync noise against the model.
    do_reset();
    repeat (3000) begin
      @(negedge i_clk);
      i_hsync = ($urandom_range(0, 9) < 3);
      i_vsync = ($urandom_range(0, 99) < 2);
    end
    @(negedge i_clk);
    check("noise_end", dut_vec(), model_vec());

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
